// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin / fixed-priority arbiter.
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam logic ARB_MODE_FIXED = 1'b0;
    localparam logic ARB_MODE_RR    = 1'b1;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// Combinational winner search: rotate so the search start sits at the top,
// take the highest set bit, then map the position back to a requester index.
module rr_pick #(
    parameter int N = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] start,
    input  logic           mode,
    output logic [IDW-1:0] winner,
    output logic           any
);
    import arb_pkg::*;

    // (a + b + 1) mod N for a, b < N; the sum never reaches 2N so one subtract suffices.
    function automatic logic [IDW-1:0] add_mod(input logic [IDW-1:0] a, input logic [IDW-1:0] b);
        logic [IDW:0] s;
        s = {1'b0, a} + {1'b0, b} + (IDW+1)'(1);
        return (s >= (IDW+1)'(N)) ? IDW'(s - (IDW+1)'(N)) : IDW'(s);
    endfunction

    logic [IDW-1:0] w_base;
    logic [N-1:0]   w_rot;
    logic [IDW-1:0] w_pos;

    // Fixed priority is the rotation that leaves the vector untouched.
    assign w_base = (mode == ARB_MODE_RR) ? start : IDW'(N - 1);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            assign w_rot[gi] = req[add_mod(IDW'(gi), w_base)];
        end
    endgenerate

    always_comb begin
        w_pos = '0;
        for (int i = 0; i < N; i++) begin
            if (w_rot[i]) w_pos = IDW'(i);
        end
    end

    assign any    = |req;
    assign winner = add_mod(w_pos, w_base);

endmodule : rr_pick

// File: rtl/rr_priority_arbiter.sv
// N-requester arbiter with a held, ack-released grant and selectable
// fixed-priority or round-robin ordering.
module rr_priority_arbiter #(
    parameter int N = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           mode,
    input  logic           ack,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_idx,
    output logic [N-1:0]   grant_onehot,
    output logic [IDW-1:0] last_idx
);
    import arb_pkg::*;

    function automatic logic [IDW-1:0] prev_idx(input logic [IDW-1:0] x);
        return (x == '0) ? IDW'(N - 1) : x - IDW'(1);
    endfunction

    arb_state_t     r_state;
    logic           r_grant_valid;
    logic [IDW-1:0] r_grant_idx;
    logic [N-1:0]   r_grant_onehot;
    logic [IDW-1:0] r_last_idx;

    logic [N-1:0]   w_pick_req;
    logic [IDW-1:0] w_start;
    logic [IDW-1:0] w_winner;
    logic           w_any;

    // On ack the owner is excluded and the search starts just below it,
    // which is the pointer value that becomes last_idx on this same edge.
    assign w_pick_req = (r_state == ARB_GRANT) ? (req & ~r_grant_onehot) : req;
    assign w_start    = prev_idx((r_state == ARB_GRANT) ? r_grant_idx : r_last_idx);

    rr_pick #(.N(N)) u_pick (
        .req    (w_pick_req),
        .start  (w_start),
        .mode   (mode),
        .winner (w_winner),
        .any    (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ARB_IDLE;
            r_grant_valid  <= 1'b0;
            r_grant_idx    <= '0;
            r_grant_onehot <= '0;
            r_last_idx     <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_state        <= ARB_GRANT;
                        r_grant_valid  <= 1'b1;
                        r_grant_idx    <= w_winner;
                        r_grant_onehot <= N'(1) << w_winner;
                    end
                end
                ARB_GRANT: begin
                    if (ack) begin
                        r_last_idx <= r_grant_idx;
                        if (w_any) begin
                            r_grant_idx    <= w_winner;
                            r_grant_onehot <= N'(1) << w_winner;
                        end else begin
                            r_state        <= ARB_IDLE;
                            r_grant_valid  <= 1'b0;
                            r_grant_onehot <= '0;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign grant_valid  = r_grant_valid;
    assign grant_idx    = r_grant_idx;
    assign grant_onehot = r_grant_onehot;
    assign last_idx     = r_last_idx;

endmodule : rr_priority_arbiter

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench for rr_priority_arbiter (N=4) with hand-computed expectations.
module tb_rr_priority_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic           mode;
    logic           ack;
    logic           grant_valid;
    logic [IDW-1:0] grant_idx;
    logic [N-1:0]   grant_onehot;
    logic [IDW-1:0] last_idx;

    int n_checks = 0;
    int n_fail   = 0;

    rr_priority_arbiter #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .mode         (mode),
        .ack          (ack),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .last_idx     (last_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic chk_grant(input string tag, input logic v, input logic [IDW-1:0] idx,
                             input logic [N-1:0] oh, input logic [IDW-1:0] last);
        check({tag, ".valid"},  32'(grant_valid),  32'(v));
        check({tag, ".idx"},    32'(grant_idx),    32'(idx));
        check({tag, ".onehot"}, 32'(grant_onehot), 32'(oh));
        check({tag, ".last"},   32'(last_idx),     32'(last));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        mode  = 1'b0;
        ack   = 1'b0;
        #1;
        chk_grant("reset0", 1'b0, 2'd0, 4'b0000, 2'd0);
        tick();
        tick();
        chk_grant("reset_hold", 1'b0, 2'd0, 4'b0000, 2'd0);

        // Fixed priority
        req   = 4'b0101;
        rst_n = 1'b1;
        tick();
        chk_grant("fix_first", 1'b1, 2'd2, 4'b0100, 2'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_grant("fix_ack1", 1'b1, 2'd0, 4'b0001, 2'd2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_grant("fix_ack2", 1'b1, 2'd2, 4'b0100, 2'd0);

        // Reset back to pointer 0 for the round-robin sweep
        #2 rst_n = 1'b0;
        #1 chk_grant("reset_mid", 1'b0, 2'd0, 4'b0000, 2'd0);
        tick();
        rst_n = 1'b1;

        // Round-robin, ack every cycle
        mode = 1'b1;
        req  = 4'b1111;
        tick();
        chk_grant("rr_g3", 1'b1, 2'd3, 4'b1000, 2'd0);
        ack = 1'b1;
        tick();
        chk_grant("rr_g2", 1'b1, 2'd2, 4'b0100, 2'd3);
        tick();
        chk_grant("rr_g1", 1'b1, 2'd1, 4'b0010, 2'd2);
        tick();
        chk_grant("rr_g0", 1'b1, 2'd0, 4'b0001, 2'd1);
        tick();
        chk_grant("rr_wrap3", 1'b1, 2'd3, 4'b1000, 2'd0);
        tick();
        chk_grant("rr_g2b", 1'b1, 2'd2, 4'b0100, 2'd3);

        // Sole requester equal to the acked owner
        req = 4'b0100;
        tick();
        ack = 1'b0;
        chk_grant("sole_idle", 1'b0, 2'd2, 4'b0000, 2'd2);
        tick();
        chk_grant("sole_regrant", 1'b1, 2'd2, 4'b0100, 2'd2);

        // Hold while req and mode change
        req = 4'b0010;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_grant("hold_g1", 1'b1, 2'd1, 4'b0010, 2'd2);
        req  = 4'b0000;
        mode = 1'b0;
        tick();
        chk_grant("hold_noreq", 1'b1, 2'd1, 4'b0010, 2'd2);
        mode = 1'b1;
        tick();
        chk_grant("hold_mode", 1'b1, 2'd1, 4'b0010, 2'd2);
        ack = 1'b1;
        tick();
        chk_grant("rel_empty", 1'b0, 2'd1, 4'b0000, 2'd1);
        tick();
        ack = 1'b0;
        chk_grant("ack_idle", 1'b0, 2'd1, 4'b0000, 2'd1);

        // RR from idle with pointer 1: search 0, 3 -> 3
        req = 4'b1000;
        tick();
        chk_grant("pre_async", 1'b1, 2'd3, 4'b1000, 2'd1);
        #3 rst_n = 1'b0;
        #1 chk_grant("async_drop", 1'b0, 2'd0, 4'b0000, 2'd0);
        tick();
        chk_grant("async_hold", 1'b0, 2'd0, 4'b0000, 2'd0);
        req   = 4'b1001;
        mode  = 1'b1;
        rst_n = 1'b1;
        tick();
        chk_grant("post_reset", 1'b1, 2'd3, 4'b1000, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rr_priority_arbiter
